bai6_cnt_ctrl: RTL and testbench

- Run controller for the team's mod-N up-counter datapath.
- Sequences start/pause/stop, latches a programmable terminal value, and supports one-shot and repeat modes.
- Reports terminal-count and completion events.
- Sits between a command source (panel/FSM) and the display/timing logic that consumes q.

---
 rtl/bai6_pkg.sv | 14 +
 rtl/bai6_cnt_core.sv | 31 +++
 rtl/bai6_cnt_ctrl.sv | 128 ++++++++++++
 tb/tb_bai6_cnt_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bai6_pkg.sv
// Shared definitions for the bai6 run controller.
// Build option BAI6_WRAP_CNT_EN exposes the pass count as output wraps.
package bai6_pkg;
  localparam int DEF_W     = 5;
  localparam int DEF_LIM   = 20;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } st_t;
endpackage

// File: rtl/bai6_cnt_core.sv
// W-bit modulo counter: counts 0..lim, wraps to 0 at lim.
module bai6_cnt_core
  import bai6_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic [W-1:0] q,
  output logic         at_lim
);

  logic [W-1:0] r_q;

  assign at_lim = (r_q == lim);
  assign q      = r_q;

  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= at_lim ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/bai6_cnt_ctrl.sv
// Start/pause/stop run controller around bai6_cnt_core.
// Define BAI6_WRAP_CNT_EN to add output wraps (completed passes).
module bai6_cnt_ctrl
  import bai6_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int LIM_DEF = DEF_LIM,
  parameter int REP_W   = DEF_REP_W
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [W-1:0]     limit,
  input  logic [REP_W-1:0] reps,
  output logic [W-1:0]     q,
  output logic             busy,
  output logic             tc,
  output logic             done,
`ifdef BAI6_WRAP_CNT_EN
  output logic [REP_W-1:0] wraps,
`endif
  output logic [1:0]       state
);

  localparam logic [W-1:0] LIM_D = W'(LIM_DEF);

  st_t              r_st;
  logic [W-1:0]     r_lim;
  logic             r_mode;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_pass;
  logic             r_done;

  logic             w_en;
  logic             w_clr;
  logic             w_at_lim;
  logic             w_go;
  logic             w_last;
  logic [REP_W-1:0] w_pass_nx;

  assign w_go      = start & ~stop & ~pause;
  assign w_pass_nx = r_pass + 1'b1;
  // one-shot ends on first terminal; repeat ends on final pass
  assign w_last    = ~r_mode |
                     ((r_reps != '0) & (w_pass_nx == r_reps));

  always_comb begin
    w_en  = 1'b0;
    w_clr = 1'b0;
    unique case (r_st)
      ST_IDLE:  w_clr = 1'b1;
      ST_RUN: begin
        if (stop)        w_clr = 1'b1;
        else if (!pause) w_en  = 1'b1;
      end
      ST_PAUSE: w_clr = stop;
      ST_DONE:  w_clr = 1'b1;
      default:  w_clr = 1'b1;
    endcase
  end

  bai6_cnt_core #(
    .W (W)
  ) u_core (
    .ck     (ck),
    .rs     (rs),
    .en     (w_en),
    .clr    (w_clr),
    .lim    (r_lim),
    .q      (q),
    .at_lim (w_at_lim)
  );

  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      r_st   <= ST_IDLE;
      r_lim  <= LIM_D;
      r_mode <= 1'b0;
      r_reps <= '0;
      r_pass <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_st)
        ST_IDLE: begin
          if (w_go) begin
            r_lim  <= (limit == '0) ? LIM_D : limit;
            r_mode <= mode;
            r_reps <= reps;
            r_pass <= '0;
            r_st   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_st <= ST_IDLE;
          end else if (pause) begin
            r_st <= ST_PAUSE;
          end else if (w_at_lim) begin
            r_pass <= w_pass_nx;
            if (w_last) begin
              r_st   <= ST_DONE;
              r_done <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop)        r_st <= ST_IDLE;
          else if (!pause) r_st <= ST_RUN;
        end
        ST_DONE: r_st <= ST_IDLE;
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign tc    = (r_st == ST_RUN) & w_at_lim;
  assign busy  = (r_st == ST_RUN) | (r_st == ST_PAUSE);
  assign done  = r_done;
  assign state = r_st;
`ifdef BAI6_WRAP_CNT_EN
  assign wraps = r_pass;
`endif

endmodule

// File: tb/tb_bai6_cnt_ctrl.sv
// Bench for bai6_cnt_ctrl: vector table, directed corners, random vs model.
// Checks wraps when BAI6_WRAP_CNT_EN is defined.
module tb_bai6_cnt_ctrl;

  logic       ck = 1'b1;
  logic       rs = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] limit = '0;
  logic [3:0] reps = '0;
  logic [4:0] q;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] state;
`ifdef BAI6_WRAP_CNT_EN
  logic [3:0] wraps;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 ck = ~ck;

  bai6_cnt_ctrl dut (
    .ck    (ck),
    .rs    (rs),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .limit (limit),
    .reps  (reps),
    .q     (q),
    .busy  (busy),
    .tc    (tc),
    .done  (done),
`ifdef BAI6_WRAP_CNT_EN
    .wraps (wraps),
`endif
    .state (state)
  );

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  // behavioural model: phase 0 idle,1 run,2 pause,3 done
  int m_ph, m_q, m_lim, m_reps, m_pass;
  bit m_rep;

  task automatic m_reset();
    m_ph = 0; m_q = 0; m_lim = 20;
    m_rep = 0; m_reps = 0; m_pass = 0;
  endtask

  task automatic m_step();
    case (m_ph)
      0: if (start && !stop && !pause) begin
        m_lim  = (limit == 0) ? 20 : int'(limit);
        m_rep  = mode;
        m_reps = reps;
        m_pass = 0;
        m_ph   = 1;
      end
      1: if (stop) begin
        m_ph = 0; m_q = 0;
      end else if (pause) begin
        m_ph = 2;
      end else if (m_q < m_lim) begin
        m_q++;
      end else begin
        m_q = 0;
        m_pass = (m_pass + 1) % 16;
        if (!m_rep || (m_reps != 0 && m_pass == m_reps))
          m_ph = 3;
      end
      2: if (stop) begin
        m_ph = 0; m_q = 0;
      end else if (!pause) begin
        m_ph = 1;
      end
      default: begin
        m_ph = 0; m_q = 0;
      end
    endcase
  endtask

  task automatic chk_model();
    chk("m_q", q, m_q);
    chk("m_state", state, m_ph);
    chk("m_tc", tc, int'(m_ph == 1 && m_q == m_lim));
    chk("m_busy", busy, int'(m_ph == 1 || m_ph == 2));
    chk("m_done", done, int'(m_ph == 3));
`ifdef BAI6_WRAP_CNT_EN
    chk("m_wraps", wraps, m_pass);
`endif
  endtask

  task automatic tick();
    @(negedge ck);
    m_step();
    @(posedge ck);
    #1;
    chk_model();
  endtask

  task automatic drive(bit s, bit p, bit pa, bit md,
                       int lm, int rp);
    start = s; stop = p; pause = pa; mode = md;
    limit = 5'(lm); reps = 4'(rp);
  endtask

  typedef struct {
    bit s, p, pa, md;
    int lm, rp;
    int eq, es;
    bit et, ed;
  } vec_t;

  vec_t tv[$];

  task automatic av(bit s, bit p, bit pa, bit md, int lm,
                    int rp, int eq, int es, bit et, bit ed);
    vec_t v;
    v.s = s; v.p = p; v.pa = pa; v.md = md;
    v.lm = lm; v.rp = rp;
    v.eq = eq; v.es = es; v.et = et; v.ed = ed;
    tv.push_back(v);
  endtask

  int dn;

  initial begin
    m_reset();
    #7;
    chk("rst_q", q, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tc", tc, 0);
    chk("rst_done", done, 0);
    rs = 1'b1;

    // repeat, limit 3, two passes
    av(1,0,0,1,3,2, 0,1,0,0);
    av(0,0,0,1,3,2, 1,1,0,0);
    av(0,0,0,1,3,2, 2,1,0,0);
    av(0,0,0,1,3,2, 3,1,1,0);
    av(0,0,0,1,3,2, 0,1,0,0);
    av(0,0,0,1,3,2, 1,1,0,0);
    av(0,0,0,1,3,2, 2,1,0,0);
    av(0,0,0,1,3,2, 3,1,1,0);
    av(0,0,0,1,3,2, 0,3,0,1);
    av(0,0,0,1,3,2, 0,0,0,0);
    // stop colliding with terminal count
    av(1,0,0,0,3,0, 0,1,0,0);
    av(0,0,0,0,3,0, 1,1,0,0);
    av(0,0,0,0,3,0, 2,1,0,0);
    av(0,0,0,0,3,0, 3,1,1,0);
    av(0,1,0,0,3,0, 0,0,0,0);
    // pause colliding with terminal count
    av(1,0,0,0,3,0, 0,1,0,0);
    av(0,0,0,0,3,0, 1,1,0,0);
    av(0,0,0,0,3,0, 2,1,0,0);
    av(0,0,0,0,3,0, 3,1,1,0);
    av(0,0,1,0,3,0, 3,2,0,0);
    av(0,0,1,0,3,0, 3,2,0,0);
    av(0,0,0,0,3,0, 3,1,1,0);
    av(0,0,0,0,3,0, 0,3,0,1);
    av(0,0,0,0,3,0, 0,0,0,0);
    // start during run ignored, settings not relatched
    av(1,0,0,0,3,0, 0,1,0,0);
    av(1,0,0,1,7,0, 1,1,0,0);
    av(0,0,0,1,7,0, 2,1,0,0);
    av(0,0,0,1,7,0, 3,1,1,0);
    av(0,0,0,1,7,0, 0,3,0,1);
    av(0,0,0,1,7,0, 0,0,0,0);
    // limit 1 toggles 0,1
    av(1,0,0,1,1,0, 0,1,0,0);
    av(0,0,0,1,1,0, 1,1,1,0);
    av(0,0,0,1,1,0, 0,1,0,0);
    av(0,0,0,1,1,0, 1,1,1,0);
    av(0,1,0,1,1,0, 0,0,0,0);

    foreach (tv[i]) begin
      drive(tv[i].s, tv[i].p, tv[i].pa, tv[i].md,
            tv[i].lm, tv[i].rp);
      tick();
      chk("tv_q", q, tv[i].eq);
      chk("tv_state", state, tv[i].es);
      chk("tv_tc", tc, tv[i].et);
      chk("tv_done", done, tv[i].ed);
      chk("tv_busy", busy,
          int'(tv[i].es == 1 || tv[i].es == 2));
    end

    // one-shot with default limit 20
    drive(1,0,0,0,0,0);
    tick();
    chk("def_q0", q, 0);
    start = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("def_q", q, i);
      chk("def_tc", tc, int'(i == 20));
    end
    tick();
    chk("def_done", done, 1);
    chk("def_dstate", state, 3);
    tick();
    chk("def_idle", state, 0);
    chk("def_busy", busy, 0);
    chk("def_done0", done, 0);

    // repeat forever then stop at q=2
    drive(1,0,0,1,4,0);
    tick();
    start = 0;
    dn = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (done) dn++;
    end
    chk("fvr_nodone", dn, 0);
    chk("fvr_q2", q, 2);
    stop = 1;
    tick();
    chk("fvr_stop_q", q, 0);
    chk("fvr_stop_st", state, 0);
    chk("fvr_stop_dn", done, 0);
    stop = 0;

    // pause at q=5 for three cycles
    drive(1,0,0,0,10,0);
    tick();
    start = 0;
    repeat (5) tick();
    chk("pau_q5", q, 5);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pau_hold", q, 5);
      chk("pau_st", state, 2);
      chk("pau_busy", busy, 1);
    end
    pause = 0;
    tick();
    chk("pau_res_st", state, 1);
    chk("pau_res_q", q, 5);
    tick();
    chk("pau_q6", q, 6);
    tick();
    chk("pau_q7", q, 7);
    stop = 1;
    tick();
    stop = 0;

    // asynchronous reset between edges
    drive(1,0,0,0,10,0);
    tick();
    start = 0;
    repeat (7) tick();
    chk("ar_q7", q, 7);
    #1 rs = 0;
    #1;
    chk("ar_q", q, 0);
    chk("ar_state", state, 0);
    chk("ar_done", done, 0);
    chk("ar_busy", busy, 0);
    m_reset();
    rs = 1;

    // maximum limit
    drive(1,0,0,0,31,0);
    tick();
    start = 0;
    repeat (31) tick();
    chk("max_q", q, 31);
    chk("max_tc", tc, 1);
    tick();
    chk("max_done", done, 1);
    chk("max_q0", q, 0);
    tick();

`ifdef BAI6_WRAP_CNT_EN
    drive(1,0,0,1,2,3);
    tick();
    start = 0;
    repeat (9) tick();
    chk("wr_done", done, 1);
    chk("wr_3", wraps, 3);
    tick();
    chk("wr_hold", wraps, 3);
    start = 1;
    tick();
    chk("wr_clr", wraps, 0);
    drive(0,1,0,0,0,0);
    tick();
    stop = 0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 30) == 0);
      pause = ($urandom_range(0, 9) == 0);
      mode  = 1'($urandom_range(0, 1));
      limit = ($urandom_range(0, 7) == 0) ?
              5'($urandom_range(0, 31)) :
              5'($urandom_range(0, 5));
      reps  = 4'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
